// File: rtl/branch_predictor_pkg.sv
// Types shared between the branch predictor and the pipeline: BTB entry
// layout, 2-bit direction counter encoding and the predictor FSM states.
package branch_predictor_pkg;

  localparam int unsigned PC_W      = 32;
  // Widest possible tag (a single-entry BTB); narrower tags are zero-extended.
  localparam int unsigned BTB_TAG_W = 30;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } BranchCounter;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } BranchPredictorState;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [PC_W-1:0]      target;
  } BtbEntry;

  // Saturating +/-1 step; the two strong states hold.
  function automatic BranchCounter counter_step(input BranchCounter cur, input logic taken);
    BranchCounter nxt;
    nxt = cur;
    if (taken && (cur != STRONG_T)) begin
      nxt = BranchCounter'(cur + 2'd1);
    end else if (!taken && (cur != STRONG_NT)) begin
      nxt = BranchCounter'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/saturating_counter_table.sv
// Branch history table: RAM-style array of 2-bit saturating counters with one
// combinational read port, one read-modify-write update port and a clear
// port used by the post-reset init walk. No reset on the storage itself.
module saturating_counter_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 256,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output BranchCounter     rd_count,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  BranchCounter counters [ENTRIES];
  BranchCounter upd_cur;

  assign rd_count = counters[rd_idx];
  assign upd_cur  = counters[upd_idx];

  // Counter writes on the falling edge; init clearing takes precedence.
  always_ff @(negedge clk) begin
    if (clr_en) begin
      counters[clr_idx] <= WEAK_NT;
    end else if (upd_en) begin
      counters[upd_idx] <= counter_step(upd_cur, upd_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side next-PC predictor (BTB + 2-bit counters) and branch-resolution
// consumer. Lookup and misprediction detection are combinational; table,
// history and FSM state update on the falling edge of clk.
// Optional macro BRANCH_HISTORY_EN selects gshare indexing (global history
// XOR pc bits); when undefined the counter table is indexed bimodally.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned BHT_ENTRIES = 256,
  parameter int unsigned HISTORY_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetchPc,
  output logic [31:0] predictedNextPC,
  output logic        isNextPcPredicted,
  output logic        isBranchTakenPredicted,
  input  logic        exValid,
  input  logic [31:0] exPc,
  input  logic        exIsBranch,
  input  logic        exBranchTaken,
  input  logic [31:0] exIrregPc,
  input  logic        exIsNextPcPredicted,
  input  logic [31:0] exPredictedNextPC,
  output logic        mispredict,
  output logic [31:0] correctPc,
  output logic        ready
);

  localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned WALK_N    = (BTB_ENTRIES > BHT_ENTRIES) ? BTB_ENTRIES : BHT_ENTRIES;
  localparam int unsigned WALK_W    = $clog2(WALK_N);
  localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(WALK_N - 1);

  BranchPredictorState state_q, state_d;
  logic [WALK_W-1:0]   walk_idx_q, walk_idx_d;
  logic                in_run;

  logic [BTB_IDX_W-1:0] fetch_btb_idx, ex_btb_idx, walk_btb_idx;
  logic [BTB_TAG_W-1:0] fetch_tag, ex_tag;
  logic [BHT_IDX_W-1:0] fetch_bht_idx, ex_bht_idx, walk_bht_idx;

  BtbEntry      btb_q [BTB_ENTRIES];
  BtbEntry      fetch_entry;
  BranchCounter fetch_ctr;
  logic         fetch_hit, fetch_taken;

  logic [31:0] actual_pc, carried_pc;
  logic        train_en, ctr_upd, btb_fill, btb_kill;

  assign in_run = (state_q == BP_RUN);
  assign ready  = in_run;

  // Address slicing
  assign fetch_btb_idx = fetchPc[BTB_IDX_W+1:2];
  assign ex_btb_idx    = exPc[BTB_IDX_W+1:2];
  assign fetch_tag     = BTB_TAG_W'(fetchPc[31:BTB_IDX_W+2]);
  assign ex_tag        = BTB_TAG_W'(exPc[31:BTB_IDX_W+2]);
  assign walk_btb_idx  = walk_idx_q[BTB_IDX_W-1:0];
  assign walk_bht_idx  = walk_idx_q[BHT_IDX_W-1:0];

`ifdef BRANCH_HISTORY_EN
  logic [HISTORY_LEN-1:0] history_q;
  logic [BHT_IDX_W-1:0]   history_ext;

  assign history_ext   = BHT_IDX_W'(history_q);
  assign fetch_bht_idx = fetchPc[BHT_IDX_W+1:2] ^ history_ext;
  assign ex_bht_idx    = exPc[BHT_IDX_W+1:2] ^ history_ext;

  // Non-speculative global history: shift in the outcome of each trained branch
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      history_q <= '0;
    end else if (ctr_upd) begin
      history_q <= HISTORY_LEN'({history_q, exBranchTaken});
    end
  end
`else
  assign fetch_bht_idx = fetchPc[BHT_IDX_W+1:2];
  assign ex_bht_idx    = exPc[BHT_IDX_W+1:2];
`endif

  // Next-state logic: walk every table index once after reset, then run
  always_comb begin
    state_d    = state_q;
    walk_idx_d = walk_idx_q;
    case (state_q)
      BP_INIT: begin
        if (walk_idx_q == WALK_LAST) begin
          state_d    = BP_RUN;
          walk_idx_d = '0;
        end else begin
          walk_idx_d = walk_idx_q + WALK_W'(1);
        end
      end
      BP_RUN: begin
        state_d = BP_RUN;
      end
    endcase
  end

  // FSM and init-walk index registers
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BP_INIT;
      walk_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      walk_idx_q <= walk_idx_d;
    end
  end

  // Fetch lookup
  assign fetch_entry            = btb_q[fetch_btb_idx];
  assign fetch_hit              = in_run && fetch_entry.valid && (fetch_entry.tag == fetch_tag);
  assign fetch_taken            = fetch_hit && ((fetch_ctr == WEAK_T) || (fetch_ctr == STRONG_T));
  assign isNextPcPredicted      = fetch_taken;
  assign isBranchTakenPredicted = fetch_taken;
  assign predictedNextPC        = fetch_taken ? fetch_entry.target : fetchPc + 32'd4;

  // Resolution: active even during the init walk so taken branches still flush
  assign actual_pc  = exIsBranch ? exIrregPc : exPc + 32'd4;
  assign carried_pc = exIsNextPcPredicted ? exPredictedNextPC : exPc + 32'd4;
  assign mispredict = exValid && (actual_pc != carried_pc);
  assign correctPc  = actual_pc;

  // Training is dropped outright while the walk runs
  assign train_en = in_run && exValid;
  assign ctr_upd  = train_en && exIsBranch;
  assign btb_fill = ctr_upd && exBranchTaken;
  assign btb_kill = train_en && !exIsBranch && exIsNextPcPredicted;

  // BTB writes: init clear, then fill on taken branch, then alias invalidate
  always_ff @(negedge clk) begin
    if (!in_run) begin
      btb_q[walk_btb_idx].valid <= 1'b0;
    end else if (btb_fill) begin
      btb_q[ex_btb_idx] <= '{valid: 1'b1, tag: ex_tag, target: exIrregPc};
    end else if (btb_kill) begin
      btb_q[ex_btb_idx].valid <= 1'b0;
    end
  end

  saturating_counter_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .rd_idx    (fetch_bht_idx),
    .rd_count  (fetch_ctr),
    .upd_en    (ctr_upd),
    .upd_idx   (ex_bht_idx),
    .upd_taken (exBranchTaken),
    .clr_en    (!in_run),
    .clr_idx   (walk_bht_idx)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (BTB_ENTRIES=16 so 0x140 aliases 0x100).
// Inputs are driven 1 time unit after the rising edge; expectations are queued
// then and compared 2 units later, well before the falling (update) edge.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] fetchPc;
  logic [31:0] predictedNextPC;
  logic        isNextPcPredicted;
  logic        isBranchTakenPredicted;
  logic        exValid;
  logic [31:0] exPc;
  logic        exIsBranch;
  logic        exBranchTaken;
  logic [31:0] exIrregPc;
  logic        exIsNextPcPredicted;
  logic [31:0] exPredictedNextPC;
  logic        mispredict;
  logic [31:0] correctPc;
  logic        ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef enum int {SIG_PNPC, SIG_ISNP, SIG_ISBT, SIG_MISP, SIG_CPC, SIG_RDY} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  branch_predictor #(
    .BTB_ENTRIES (16),
    .BHT_ENTRIES (256),
    .HISTORY_LEN (8)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .fetchPc                (fetchPc),
    .predictedNextPC        (predictedNextPC),
    .isNextPcPredicted      (isNextPcPredicted),
    .isBranchTakenPredicted (isBranchTakenPredicted),
    .exValid                (exValid),
    .exPc                   (exPc),
    .exIsBranch             (exIsBranch),
    .exBranchTaken          (exBranchTaken),
    .exIrregPc              (exIrregPc),
    .exIsNextPcPredicted    (exIsNextPcPredicted),
    .exPredictedNextPC      (exPredictedNextPC),
    .mispredict             (mispredict),
    .correctPc              (correctPc),
    .ready                  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.sig)
        SIG_PNPC: obs = predictedNextPC;
        SIG_ISNP: obs = {31'b0, isNextPcPredicted};
        SIG_ISBT: obs = {31'b0, isBranchTakenPredicted};
        SIG_MISP: obs = {31'b0, mispredict};
        SIG_CPC:  obs = correctPc;
        default:  obs = {31'b0, ready};
      endcase
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic expect_lookup(input string tag, input logic [31:0] nxt, input logic taken);
    expect_val({tag, ".pc"},   SIG_PNPC, nxt);
    expect_val({tag, ".isnp"}, SIG_ISNP, {31'b0, taken});
    expect_val({tag, ".isbt"}, SIG_ISBT, {31'b0, taken});
  endtask

  task automatic expect_res(input string tag, input logic misp, input logic [31:0] cpc);
    expect_val({tag, ".misp"}, SIG_MISP, {31'b0, misp});
    expect_val({tag, ".cpc"},  SIG_CPC,  cpc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
    drain();
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic isb, input logic tk,
                        input logic [31:0] irreg, input logic isnp, input logic [31:0] pnpc);
    exValid             = v;
    exPc                = pc;
    exIsBranch          = isb;
    exBranchTaken       = tk;
    exIrregPc           = irreg;
    exIsNextPcPredicted = isnp;
    exPredictedNextPC   = pnpc;
  endtask

  task automatic ex_idle();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Called right after reset release; checks ready stays low for 256 cycles
  task automatic walk_to_ready();
    for (int i = 0; i < 256; i++) begin
      if (i == 251) ex_idle();
      expect_val("init_ready", SIG_RDY, 32'd0);
      if (i % 64 == 0) begin
        fetchPc = 32'h100;
        expect_lookup("init_lookup", 32'h104, 1'b0);
      end
      if (i == 250) begin
        set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        expect_res("init_flush", 1'b1, 32'h200);
      end
      #1;
      drain();
      next_cycle();
    end
    expect_val("ready_rise", SIG_RDY, 32'd1);
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned misp_total;
    int unsigned misp_late;
    logic        p_isnp;
    logic [31:0] p_pc;
    logic [31:0] irreg;
    logic [31:0] carried;
    logic        tk;

    rst     = 1'b0;
    fetchPc = 32'h1000;
    ex_idle();
    #1;
    expect_val("reset_ready", SIG_RDY, 32'd0);
    expect_lookup("reset_lookup", 32'h1004, 1'b0);
    expect_res("reset_res", 1'b0, 32'h4);
    #1;
    drain();

    next_cycle();
    rst = 1'b1;
    walk_to_ready();

    // Updates attempted during the walk must have been dropped
    next_cycle();
    ex_idle();
    fetchPc = 32'h100;
    expect_lookup("post_init_lookup", 32'h104, 1'b0);
    settle();

`ifndef BRANCH_HISTORY_EN
    // Two unpredicted taken branches train 01 -> 10 -> 11
    next_cycle();
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    expect_res("br_first", 1'b1, 32'h200);
    settle();
    next_cycle();
    expect_res("br_second", 1'b1, 32'h200);
    expect_lookup("lookup_after_one", 32'h200, 1'b1);
    settle();
    // Correctly predicted taken branch: no flush, counter saturates at 11
    next_cycle();
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
    expect_res("br_correct", 1'b0, 32'h200);
    settle();
    next_cycle();
    ex_idle();
    expect_lookup("lookup_trained", 32'h200, 1'b1);
    settle();

    // Predicted taken, resolved not taken: 11 -> 10, still predicts taken
    next_cycle();
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 1'b1, 32'h200);
    expect_res("br_not_taken", 1'b1, 32'h104);
    settle();
    next_cycle();
    ex_idle();
    expect_lookup("lookup_weak_t", 32'h200, 1'b1);
    settle();

    // Non-branch aliasing the BTB entry with a carried prediction
    next_cycle();
    set_ex(1'b1, 32'h140, 1'b0, 1'b0, 32'hDEAD_BEE0, 1'b1, 32'h200);
    expect_res("alias_flush", 1'b1, 32'h144);
    settle();
    next_cycle();
    ex_idle();
    expect_lookup("lookup_invalidated", 32'h104, 1'b0);
    settle();

    // Same-cycle lookup and update: old value now, new value next cycle
    next_cycle();
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h280, 1'b0, 32'h0);
    expect_lookup("same_cycle_old", 32'h104, 1'b0);
    expect_res("same_cycle_res", 1'b1, 32'h280);
    settle();
    next_cycle();
    ex_idle();
    expect_lookup("same_cycle_new", 32'h280, 1'b1);
    settle();

    // Two not-taken resolutions: 11 -> 10 (taken) -> 01 (not taken)
    next_cycle();
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 1'b1, 32'h280);
    expect_res("nt1_res", 1'b1, 32'h104);
    settle();
    next_cycle();
    ex_idle();
    expect_lookup("after_nt1", 32'h280, 1'b1);
    settle();
    next_cycle();
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 1'b1, 32'h280);
    expect_res("nt2_res", 1'b1, 32'h104);
    settle();
    next_cycle();
    ex_idle();
    expect_lookup("after_nt2", 32'h104, 1'b0);
    settle();

    // Plain sequential instruction; then a bubble that must not train
    next_cycle();
    set_ex(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_res("seq_ok", 1'b0, 32'h504);
    settle();
    next_cycle();
    set_ex(1'b0, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    expect_res("bubble_res", 1'b0, 32'h200);
    settle();
    next_cycle();
    ex_idle();
    expect_lookup("after_bubble", 32'h104, 1'b0);
    settle();
`endif

    // Reset during RUN, then again mid-walk; the full walk must repeat
    next_cycle();
    rst = 1'b0;
    fetchPc = 32'h100;
    expect_val("rerun_reset_ready", SIG_RDY, 32'd0);
    expect_lookup("rerun_reset_lookup", 32'h104, 1'b0);
    settle();
    next_cycle();
    rst = 1'b1;
    repeat (100) next_cycle();
    expect_val("mid_walk_ready", SIG_RDY, 32'd0);
    #1;
    drain();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    walk_to_ready();
    next_cycle();
    ex_idle();
    fetchPc = 32'h100;
    expect_lookup("post_rewalk_lookup", 32'h104, 1'b0);
    settle();

    // Alternating taken / not-taken branch at 0x300
    misp_total = 0;
    misp_late  = 0;
    for (int it = 0; it < 20; it++) begin
      next_cycle();
      ex_idle();
      fetchPc = 32'h300;
      #2;
      p_isnp = isNextPcPredicted;
      p_pc   = predictedNextPC;
      next_cycle();
      tk      = (it % 2 == 0);
      irreg   = tk ? 32'h400 : 32'h304;
      carried = p_isnp ? p_pc : 32'h304;
      set_ex(1'b1, 32'h300, 1'b1, tk, irreg, p_isnp, p_pc);
      expect_res($sformatf("alt%0d", it), (irreg != carried), irreg);
      #2;
      if (mispredict) begin
        misp_total++;
        if (it >= 12) misp_late++;
      end
      drain();
    end
    next_cycle();
    ex_idle();
`ifdef BRANCH_HISTORY_EN
    check_eq("gshare_late_mispredicts", misp_late, 32'd0);
`else
    check_eq("bimodal_mispredicts_ge_half", {31'b0, (misp_total >= 10)}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
